uart_frame_parser: RTL

- Sits directly downstream of the UART receiver and consumes its received-byte strobe.
- Finds framed packets: SOF 0xAA, LEN, LEN payload bytes, checksum.
- Stores the payload in an internal buffer and checks the checksum before anything is released (store-and-forward).
- Streams validated payload to the core over a valid/ready handshake. Reports per-frame status pulses.

---
 rtl/uart_frame_parser_if.sv | 24 ++
 rtl/uart_frame_parser.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/uart_frame_parser_if.sv
// Receive-strobe, payload-stream and status signals of uart_frame_parser.
// The parser uses the slave modport; the UART side and core side together act as master.
interface uart_frame_parser_if;
  logic       RX_VALID;
  logic [7:0] RX_DATA;
  logic       OUT_VALID;
  logic       OUT_READY;
  logic [7:0] OUT_DATA;
  logic       OUT_LAST;
  logic       FRAME_OK;
  logic       FRAME_ERR;
  logic [1:0] ERR_CODE;
  logic       OVERRUN;

  modport slave (
    input  RX_VALID, RX_DATA, OUT_READY,
    output OUT_VALID, OUT_DATA, OUT_LAST, FRAME_OK, FRAME_ERR, ERR_CODE, OVERRUN
  );

  modport master (
    output RX_VALID, RX_DATA, OUT_READY,
    input  OUT_VALID, OUT_DATA, OUT_LAST, FRAME_OK, FRAME_ERR, ERR_CODE, OVERRUN
  );
endinterface

// File: rtl/uart_frame_parser.sv
// Store-and-forward parser for SOF/LEN/payload/checksum frames from a UART receiver.
// Optional inter-byte idle timeout: define UART_FRAME_TIMEOUT_EN.
module uart_frame_parser #(
  parameter logic [7:0]  SOF_BYTE       = 8'hAA,
  parameter int unsigned MAX_PAYLOAD    = 16,
  parameter int unsigned TIMEOUT_CLOCKS = 17360
) (
  input logic                CLK,
  input logic                RESET,
  uart_frame_parser_if.slave bus
);
  localparam int         PTR_W    = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
  localparam logic [7:0] MAX_LEN  = 8'(MAX_PAYLOAD);
  localparam logic [1:0] ERR_LEN  = 2'b01;
  localparam logic [1:0] ERR_CSUM = 2'b10;

  if (MAX_PAYLOAD == 0 || MAX_PAYLOAD > 255 ||
      TIMEOUT_CLOCKS == 0 || TIMEOUT_CLOCKS > 65535) begin : g_bad_params
    $error("uart_frame_parser: MAX_PAYLOAD or TIMEOUT_CLOCKS out of range");
  end

  typedef enum logic [2:0] {S_IDLE, S_LEN, S_PAYLOAD, S_CSUM, S_DRAIN} state_t;

  state_t           state_q, state_d;
  logic [PTR_W-1:0] len_m1_q, len_m1_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]       sum_q, sum_d;
  logic             frame_ok_q, frame_ok_d;
  logic             frame_err_q, frame_err_d;
  logic [1:0]       err_code_q, err_code_d;
  logic             overrun_q, overrun_d;
  logic             buf_we;
  logic             timeout_hit;
  logic [7:0]       buf_q [MAX_PAYLOAD];

`ifdef UART_FRAME_TIMEOUT_EN
  localparam logic [15:0] TO_LAST     = 16'(TIMEOUT_CLOCKS - 1);
  localparam logic [1:0]  ERR_TIMEOUT = 2'b11;

  logic [15:0] idle_cnt_q, idle_cnt_d;
  logic        in_frame;

  // Counter only runs while a frame is partially received; any byte restarts it.
  assign in_frame    = (state_q == S_LEN) || (state_q == S_PAYLOAD) || (state_q == S_CSUM);
  assign timeout_hit = in_frame && !bus.RX_VALID && (idle_cnt_q == TO_LAST);

  always_comb begin
    idle_cnt_d = '0;
    if (in_frame && !bus.RX_VALID && !timeout_hit) idle_cnt_d = idle_cnt_q + 16'd1;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) idle_cnt_q <= '0;
    else       idle_cnt_q <= idle_cnt_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    len_m1_d    = len_m1_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    sum_d       = sum_q;
    buf_we      = 1'b0;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    err_code_d  = err_code_q;
    overrun_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.RX_VALID && bus.RX_DATA == SOF_BYTE) state_d = S_LEN;
      end
      S_LEN: begin
        if (bus.RX_VALID) begin
          if (bus.RX_DATA == 8'd0 || bus.RX_DATA > MAX_LEN) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_LEN;
            state_d     = S_IDLE;
          end else begin
            len_m1_d = PTR_W'(bus.RX_DATA - 8'd1);
            sum_d    = bus.RX_DATA;
            wr_ptr_d = '0;
            state_d  = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (bus.RX_VALID) begin
          buf_we = 1'b1;
          sum_d  = sum_q + bus.RX_DATA;
          if (wr_ptr_q == len_m1_q) state_d = S_CSUM;
          else                      wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
      end
      S_CSUM: begin
        if (bus.RX_VALID) begin
          if (8'(sum_q + bus.RX_DATA) == 8'd0) begin
            frame_ok_d = 1'b1;
            rd_ptr_d   = '0;
            state_d    = S_DRAIN;
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_CSUM;
            state_d     = S_IDLE;
          end
        end
      end
      S_DRAIN: begin
        // No RX backpressure: anything arriving now is lost and flagged.
        if (bus.RX_VALID) overrun_d = 1'b1;
        if (bus.OUT_READY) begin
          if (rd_ptr_q == len_m1_q) state_d = S_IDLE;
          else                      rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef UART_FRAME_TIMEOUT_EN
    if (timeout_hit) begin
      frame_err_d = 1'b1;
      err_code_d  = ERR_TIMEOUT;
      state_d     = S_IDLE;
    end
`endif
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      len_m1_q    <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      sum_q       <= '0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_m1_q    <= len_m1_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      sum_q       <= sum_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      err_code_q  <= err_code_d;
      overrun_q   <= overrun_d;
    end
  end

  // Payload storage carries no reset; it is only read back after being written.
  always_ff @(posedge CLK) begin
    if (buf_we) buf_q[wr_ptr_q] <= bus.RX_DATA;
  end

  assign bus.OUT_VALID = (state_q == S_DRAIN);
  assign bus.OUT_DATA  = bus.OUT_VALID ? buf_q[rd_ptr_q] : 8'd0;
  assign bus.OUT_LAST  = bus.OUT_VALID && (rd_ptr_q == len_m1_q);
  assign bus.FRAME_OK  = frame_ok_q;
  assign bus.FRAME_ERR = frame_err_q;
  assign bus.ERR_CODE  = err_code_q;
  assign bus.OVERRUN   = overrun_q;
endmodule
